instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/instr_pack.sv | 79 +++++++
 rtl/instr_encoder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the instruction-memory writer.
// Opcodes, command kinds and encoder FSM states.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] K_LOAD   = 3'd0;
  localparam logic [2:0] K_STORE  = 3'd1;
  localparam logic [2:0] K_RTYPE  = 3'd2;
  localparam logic [2:0] K_BRANCH = 3'd3;
  localparam logic [2:0] K_ITYPE  = 3'd4;
  localparam logic [2:0] K_JAL    = 3'd5;
  localparam logic [2:0] K_LI     = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT1,
    S_EMIT2
  } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I word builder for one command.
// In: kind, rd/rs1/rs2, funct3, funct7b5, imm, phase. Out: word, two_word, range_err.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] imm,
  input  logic        phase,
  output logic [31:0] word,
  output logic        two_word,
  output logic        range_err
);

  logic        fit12;
  logic        fit13;
  logic        fit21;
  logic [19:0] hi20;
  logic [11:0] itop;

  always_comb begin
    fit12 = (&imm[31:11]) | ~(|imm[31:11]);
    fit13 = (&imm[31:12]) | ~(|imm[31:12]);
    fit21 = (&imm[31:20]) | ~(|imm[31:20]);
    // LUI upper rounds up when the ADDI low part is negative.
    hi20  = imm[31:12] + {19'd0, imm[11]};
    // Shift-right-immediate carries the arith/logical bit.
    itop  = (funct3 == 3'b101)
          ? {1'b0, funct7b5, 5'd0, imm[4:0]}
          : imm[11:0];
    word      = '0;
    two_word  = 1'b0;
    range_err = 1'b0;
    unique case (1'b1)
      (kind == K_LOAD): begin
        range_err = ~fit12;
        word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
      end
      (kind == K_STORE): begin
        range_err = ~fit12;
        word = {imm[11:5], rs2, rs1, 3'b010,
                imm[4:0], OP_STORE};
      end
      (kind == K_RTYPE): begin
        word = {1'b0, funct7b5, 5'd0, rs2, rs1,
                funct3, rd, OP_RTYPE};
      end
      (kind == K_BRANCH): begin
        range_err = ~fit13 | imm[0];
        word = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                imm[4:1], imm[11], OP_BRANCH};
      end
      (kind == K_ITYPE): begin
        range_err = ~fit12;
        word = {itop, rs1, funct3, rd, OP_ITYPE};
      end
      (kind == K_JAL): begin
        range_err = ~fit21 | imm[0];
        word = {imm[20], imm[10:1], imm[11],
                imm[19:12], rd, OP_JAL};
      end
      (kind == K_LI): begin
        two_word = ~fit12;
        if (fit12)
          word = {imm[11:0], 5'd0, 3'b000, rd, OP_ITYPE};
        else if (!phase)
          word = {hi20, rd, OP_LUI};
        else
          word = {imm[11:0], rd, 3'b000, rd, OP_ITYPE};
      end
      default: range_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Command-to-RV32I encoder writing the core's instruction memory.
// cmd_* handshake in; we/waddr/wdata write port and err pulse out.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] imm,
  input  logic        addr_load,
  input  logic [31:0] addr_in,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        err
);

  state_e      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  kind_q, kind_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [2:0]  f3_q, f3_d;
  logic        f7_q, f7_d;
  logic [31:0] imm_q, imm_d;

  logic        idle;
  logic        accept;
  logic [31:0] word;
  logic        two_word;
  logic        range_err;

  assign idle      = (state_q == S_IDLE);
  assign cmd_ready = reset & idle;
  assign accept    = cmd_valid & cmd_ready;

  // Live inputs build the first word at acceptance;
  // held fields build the second word of a long LI.
  instr_pack u_pack (
    .kind      (idle ? cmd_kind : kind_q),
    .rd        (idle ? rd       : rd_q),
    .rs1       (idle ? rs1      : rs1_q),
    .rs2       (idle ? rs2      : rs2_q),
    .funct3    (idle ? funct3   : f3_q),
    .funct7b5  (idle ? funct7b5 : f7_q),
    .imm       (idle ? imm      : imm_q),
    .phase     (~idle),
    .word      (word),
    .two_word  (two_word),
    .range_err (range_err)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    kind_d  = kind_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    imm_d   = imm_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (accept) begin
          kind_d  = cmd_kind;
          rd_d    = rd;
          rs1_d   = rs1;
          rs2_d   = rs2;
          f3_d    = funct3;
          f7_d    = funct7b5;
          imm_d   = imm;
          state_d = S_EMIT1;
          if (range_err) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = word;
            ptr_d   = ptr_q + 32'd4;
          end
        end else if (addr_load) begin
          ptr_d = addr_in;
        end
      end
      (state_q == S_EMIT1): begin
        state_d = S_IDLE;
        if (two_word) begin
          we_d    = 1'b1;
          waddr_d = ptr_q;
          wdata_d = word;
          ptr_d   = ptr_q + 32'd4;
          state_d = S_EMIT2;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      kind_q  <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      f3_q    <= '0;
      f7_q    <= 1'b0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      err_q   <= err_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      kind_q  <= kind_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
      imm_q   <= imm_d;
    end
  end

  assign we    = we_q;
  assign err   = err_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule
